pc_fetch_sequencer: RTL and testbench

- Owns the program counter and sequences instruction fetch from the instruction ROM using a req/ack handshake.
- Presents each fetched instruction and its PC to the decode stage.
- Applies next-PC selection by priority: exception, jump, branch, sequential.
- Times out stalled fetches and detects misaligned targets; both redirect to the exception vector.

---
 rtl/pc_fetch_sequencer.sv | 94 +++++++++
 tb/tb_pc_fetch_sequencer.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer: owns the PC, fetches from ROM over req/ack and hands instructions to decode
module pc_fetch_sequencer #(
   parameter int N = 32,
   parameter logic [N-1:0] RESET_PC = 32'h0040_0000,
   parameter logic [N-1:0] EXC_VECTOR = 32'h8000_0180,
   parameter int MAX_WAIT = 15
) (
   input  logic         clk,
   input  logic         reset,
   output logic         imem_req,
   output logic [N-1:0] imem_addr,
   input  logic         imem_ack,
   input  logic [31:0]  imem_rdata,
   output logic         instr_valid,
   output logic [31:0]  instr,
   output logic [N-1:0] instr_pc,
   input  logic         stall,
   input  logic         exception,
   input  logic         jump,
   input  logic [N-1:0] jump_target,
   input  logic         branch_taken,
   input  logic [N-1:0] branch_target,
   output logic         fetch_error
);
   typedef enum logic [1:0] {IDLE, REQ, ISSUE, ERR} state_t;
   localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);
   state_t state, state_n;
   logic [N-1:0] pc, pc_n, instr_pc_n, target;
   logic [7:0] wait_cnt, wait_cnt_n;
   logic [31:0] instr_n;
   logic instr_valid_n, fetch_error_n, misaligned;
   assign imem_req = state == REQ;
   assign imem_addr = pc;
   assign target = exception ? EXC_VECTOR : jump ? jump_target : branch_taken ? branch_target : instr_pc + N'(4);
   assign misaligned = !exception && (jump || branch_taken) && target[1:0] != 2'b00;
   // next-state and next-register values; redirects only matter in an unstalled ISSUE
   always_comb begin
      state_n = state;
      pc_n = pc;
      wait_cnt_n = wait_cnt;
      instr_n = instr;
      instr_pc_n = instr_pc;
      instr_valid_n = instr_valid;
      fetch_error_n = 1'b0;
      case (state)
         IDLE: state_n = REQ;
         REQ: begin
            if (imem_ack) begin
               instr_n = imem_rdata;
               instr_pc_n = pc;
               instr_valid_n = 1'b1;
               wait_cnt_n = '0;
               state_n = ISSUE;
            end else if (wait_cnt == WAIT_LAST) begin
               pc_n = EXC_VECTOR;
               fetch_error_n = 1'b1;
               wait_cnt_n = '0;
               state_n = ERR;
            end else begin
               wait_cnt_n = wait_cnt + 8'd1;
            end
         end
         ISSUE: begin
            if (!stall) begin
               instr_valid_n = 1'b0;
               pc_n = misaligned ? EXC_VECTOR : target;
               fetch_error_n = misaligned;
               state_n = misaligned ? ERR : REQ;
            end
         end
         default: state_n = REQ;
      endcase
   end
   // state and datapath registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
         pc <= RESET_PC;
         wait_cnt <= '0;
         instr <= '0;
         instr_pc <= '0;
         instr_valid <= 1'b0;
         fetch_error <= 1'b0;
      end else begin
         state <= state_n;
         pc <= pc_n;
         wait_cnt <= wait_cnt_n;
         instr <= instr_n;
         instr_pc <= instr_pc_n;
         instr_valid <= instr_valid_n;
         fetch_error <= fetch_error_n;
      end
   end
endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// tb_pc_fetch_sequencer: directed scoreboard bench for pc_fetch_sequencer
module tb_pc_fetch_sequencer;
   logic clk = 1'b0;
   logic reset = 1'b0;
   logic imem_req, imem_ack = 1'b0;
   logic [31:0] imem_addr, imem_rdata, instr, instr_pc;
   logic instr_valid, fetch_error;
   logic stall = 1'b0, exception = 1'b0, jump = 1'b0, branch_taken = 1'b0;
   logic [31:0] jump_target = '0, branch_target = '0;
   int total = 0, bad = 0;
   logic [63:0] sb[$];

   pc_fetch_sequencer dut (
      .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
      .instr(instr), .instr_pc(instr_pc), .stall(stall), .exception(exception),
      .jump(jump), .jump_target(jump_target), .branch_taken(branch_taken),
      .branch_target(branch_target), .fetch_error(fetch_error)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] rom(input logic [31:0] a);
      return a ^ 32'h1357_9BDF;
   endfunction
   assign imem_rdata = rom(imem_addr);

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic fetch(input string tag, input logic [31:0] addr);
      logic [63:0] e;
      chk({tag, ".req"}, 64'(imem_req), 64'd1);
      chk({tag, ".addr"}, 64'(imem_addr), 64'(addr));
      imem_ack = 1'b1;
      sb.push_back({rom(addr), addr});
      tick();
      imem_ack = 1'b0;
      chk({tag, ".valid"}, 64'(instr_valid), 64'd1);
      if (sb.size() == 0) chk({tag, ".sb_empty"}, 64'd0, 64'd1);
      else begin
         e = sb.pop_front();
         chk({tag, ".instr"}, 64'(instr), 64'(e[63:32]));
         chk({tag, ".pc"}, 64'(instr_pc), 64'(e[31:0]));
      end
   endtask

   initial begin
      tick();
      tick();
      chk("rst.valid", 64'(instr_valid), 64'd0);
      chk("rst.instr", 64'(instr), 64'd0);
      chk("rst.ipc", 64'(instr_pc), 64'd0);
      chk("rst.err", 64'(fetch_error), 64'd0);
      chk("rst.req", 64'(imem_req), 64'd0);
      chk("rst.addr", 64'(imem_addr), 64'h0040_0000);
      reset = 1'b1;
      tick();
      fetch("seq0", 32'h0040_0000);
      tick();
      chk("seq0.drop", 64'(instr_valid), 64'd0);
      fetch("seq1", 32'h0040_0004);
      tick();
      chk("seq1.drop", 64'(instr_valid), 64'd0);
      fetch("seq2", 32'h0040_0008);
      jump = 1'b1; jump_target = 32'h0040_0100;
      branch_taken = 1'b1; branch_target = 32'h0040_0200;
      tick();
      jump = 1'b0; branch_taken = 1'b0;
      fetch("jmp", 32'h0040_0100);
      exception = 1'b1; jump = 1'b1; branch_taken = 1'b1;
      tick();
      exception = 1'b0; jump = 1'b0; branch_taken = 1'b0;
      fetch("exc", 32'h8000_0180);
      stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h0040_0040;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall.valid", 64'(instr_valid), 64'd1);
         chk("stall.ipc", 64'(instr_pc), 64'h8000_0180);
         chk("stall.instr", 64'(instr), 64'(rom(32'h8000_0180)));
         chk("stall.req", 64'(imem_req), 64'd0);
      end
      stall = 1'b0;
      tick();
      branch_taken = 1'b0;
      fetch("br", 32'h0040_0040);
      tick();
      for (int i = 0; i < 14; i++) begin
         chk("to.req", 64'(imem_req), 64'd1);
         tick();
         chk("to.noerr", 64'(fetch_error), 64'd0);
      end
      tick();
      chk("to.err", 64'(fetch_error), 64'd1);
      chk("to.reqlow", 64'(imem_req), 64'd0);
      chk("to.addr", 64'(imem_addr), 64'h8000_0180);
      tick();
      chk("to.errdrop", 64'(fetch_error), 64'd0);
      for (int i = 0; i < 13; i++) begin
         tick();
         chk("late.noerr", 64'(fetch_error), 64'd0);
      end
      fetch("late", 32'h8000_0180);
      chk("late.err", 64'(fetch_error), 64'd0);
      branch_taken = 1'b1; branch_target = 32'h0040_0042;
      tick();
      branch_taken = 1'b0;
      chk("mis.err", 64'(fetch_error), 64'd1);
      chk("mis.req", 64'(imem_req), 64'd0);
      chk("mis.valid", 64'(instr_valid), 64'd0);
      chk("mis.addr", 64'(imem_addr), 64'h8000_0180);
      tick();
      chk("mis.errdrop", 64'(fetch_error), 64'd0);
      fetch("mis", 32'h8000_0180);
      tick();
      chk("mid.addr", 64'(imem_addr), 64'h8000_0184);
      imem_ack = 1'b1; reset = 1'b0;
      tick();
      imem_ack = 1'b0; reset = 1'b1;
      chk("mid.valid", 64'(instr_valid), 64'd0);
      chk("mid.instr", 64'(instr), 64'd0);
      chk("mid.req", 64'(imem_req), 64'd0);
      chk("mid.addr0", 64'(imem_addr), 64'h0040_0000);
      tick();
      fetch("post", 32'h0040_0000);
      chk("sb.left", 64'(sb.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
